// File: rtl/stc_pkg.sv
// Shared types and constants for the sparse tensor core A-operand feed.
package stc_pkg;
    localparam int SKID_DEPTH = 2;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } st_e;

    function automatic int unsigned beat_cnt(
        input int unsigned len,
        input int unsigned npe
    );
        return (len + npe - 1) / npe;
    endfunction
endpackage

// File: rtl/stc_a_dn_ctrl_if.sv
// Command, A-buffer read and DN beat signals of stc_a_dn_ctrl.
interface stc_a_dn_ctrl_if #(
    parameter int DW_DATA = 16,
    parameter int N_PE    = 4,
    parameter int AW      = 8
) ();
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [AW-1:0]             cmd_base;
    logic [AW:0]               cmd_len;
    logic                      buf_rd_en;
    logic [AW-1:0]             buf_rd_addr;
    logic [N_PE*DW_DATA-1:0]   buf_rd_data;
    logic                      dn_valid;
    logic                      dn_ready;
    logic [N_PE*DW_DATA-1:0]   dn_a;
    logic [N_PE-1:0]           dn_mask;
    logic                      dn_last;
    logic                      done;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, buf_rd_data, dn_ready,
        output cmd_ready, buf_rd_en, buf_rd_addr,
        output dn_valid, dn_a, dn_mask, dn_last, done
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, buf_rd_data, dn_ready,
        input  cmd_ready, buf_rd_en, buf_rd_addr,
        input  dn_valid, dn_a, dn_mask, dn_last, done
    );
endinterface

// File: rtl/stc_skid_fifo.sv
// Two-entry skid FIFO holding {last, mask, data} beats; empty head reads as zero.
module stc_skid_fifo
    import stc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0] mem [SKID_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop;
    logic         wr;

    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign wr        = push && (count != CNT_W'(SKID_DEPTH) || pop);
    assign dout      = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= !wr_ptr;
            if (pop) rd_ptr <= !rd_ptr;
            if (wr && !pop) count <= count + 1'b1;
            else if (pop && !wr) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/stc_a_dn_ctrl.sv
// A-operand DN beat scheduler: buffer reads -> skid FIFO -> masked beats.
// Optional stall counter enabled by STC_A_DN_CTRL_PERF_EN.
module stc_a_dn_ctrl
    import stc_pkg::*;
#(
    parameter int N       = 16,
    parameter int DW_DATA = 16,
    parameter int N_PE    = 4,
    parameter int AW      = 8
) (
    input  logic           clk,
    input  logic           reset,
    stc_a_dn_ctrl_if.master bus
`ifdef STC_A_DN_CTRL_PERF_EN
    ,
    output logic [31:0]    perf_stall_cnt
`endif
);
    localparam int DWB = N_PE * DW_DATA;
    localparam int PW  = 1 + N_PE + DWB;

    if (N < 1 || N_PE < 1 || DW_DATA < 1) begin : g_param_chk
        $error("stc_a_dn_ctrl: invalid parameters");
    end

    st_e              st;
    st_e              st_nx;
    logic [AW-1:0]    addr;
    logic [AW:0]      reads_left;
    logic [N_PE-1:0]  last_mask;
    logic [N_PE-1:0]  cmd_mask;
    int               cmd_rem;
    logic             infl;
    logic             infl_last;
    logic [N_PE-1:0]  infl_mask;
    logic [CNT_W-1:0] fcnt;
    logic [2:0]       occ_nx;
    logic             fvalid;
    logic [PW-1:0]    fdin;
    logic [PW-1:0]    fdout;
    logic [DWB-1:0]   rd_masked;
    logic             hs_cmd;
    logic             hs_dn;
    logic             rd;
    logic             rd_last;

    assign hs_cmd  = bus.cmd_valid && bus.cmd_ready;
    assign hs_dn   = fvalid && bus.dn_ready;
    assign rd_last = reads_left == (AW+1)'(1);

    // Credit the beat leaving this cycle so a ready sink sees no bubbles.
    assign occ_nx = 3'(fcnt) + 3'(infl) - 3'(hs_dn);

    always_comb begin
        cmd_rem = int'(bus.cmd_len) % N_PE;
        for (int i = 0; i < N_PE; i++) begin
            cmd_mask[i] = (cmd_rem == 0) || (i < cmd_rem);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) st <= ST_IDLE;
        else        st <= st_nx;
    end

    always_comb begin
        st_nx         = st;
        bus.cmd_ready = 1'b0;
        bus.done      = 1'b0;
        rd            = 1'b0;
        unique case (st)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    st_nx = (bus.cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                rd = (reads_left != '0) && (occ_nx < 3'(SKID_DEPTH));
                if (rd && rd_last) st_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (hs_dn && fdout[PW-1]) st_nx = ST_DONE;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                st_nx    = ST_IDLE;
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    assign bus.buf_rd_en   = rd;
    assign bus.buf_rd_addr = addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr       <= '0;
            reads_left <= '0;
            last_mask  <= '0;
            infl       <= 1'b0;
            infl_last  <= 1'b0;
            infl_mask  <= '0;
        end else begin
            infl      <= rd;
            infl_last <= rd && rd_last;
            infl_mask <= (rd && rd_last) ? last_mask : '1;
            if (hs_cmd) begin
                addr       <= bus.cmd_base;
                reads_left <= (AW+1)'(beat_cnt(int'(bus.cmd_len), N_PE));
                last_mask  <= cmd_mask;
            end else if (rd) begin
                addr       <= addr + 1'b1;
                reads_left <= reads_left - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PE; i++) begin
            rd_masked[i*DW_DATA +: DW_DATA] = infl_mask[i]
                ? bus.buf_rd_data[i*DW_DATA +: DW_DATA] : '0;
        end
    end

    assign fdin = {infl_last, infl_mask, rd_masked};

    stc_skid_fifo #(.W(PW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (infl),
        .din       (fdin),
        .out_valid (fvalid),
        .out_ready (bus.dn_ready),
        .dout      (fdout),
        .count     (fcnt)
    );

    assign bus.dn_valid = fvalid;
    assign bus.dn_last  = fdout[PW-1];
    assign bus.dn_mask  = fdout[DWB +: N_PE];
    assign bus.dn_a     = fdout[DWB-1:0];

`ifdef STC_A_DN_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset || hs_cmd) begin
            perf_stall_cnt <= '0;
        end else if (fvalid && !bus.dn_ready && perf_stall_cnt != '1) begin
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_stc_a_dn_ctrl.sv
// Directed vector bench for stc_a_dn_ctrl (buffer model word k = {k+3,k+7,k+9,k+1}).
module tb_stc_a_dn_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   ncmp = 0;
    int   errs = 0;

    always #5 clk = !clk;

    stc_a_dn_ctrl_if #(.DW_DATA(16), .N_PE(4), .AW(8)) intf ();

`ifdef STC_A_DN_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    stc_a_dn_ctrl #(.N(16), .DW_DATA(16), .N_PE(4), .AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.master)
`ifdef STC_A_DN_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic logic [63:0] word(input logic [7:0] k);
        logic [15:0] kk;
        kk = {8'h00, k};
        return {kk + 16'd3, kk + 16'd7, kk + 16'd9, kk + 16'd1};
    endfunction

    function automatic logic [63:0] mask_word(input logic [63:0] w, input logic [3:0] m);
        logic [63:0] r;
        r = w;
        for (int i = 0; i < 4; i++) if (!m[i]) r[i*16 +: 16] = 16'h0;
        return r;
    endfunction

    initial intf.buf_rd_data = '0;
    always @(posedge clk) begin
        if (intf.buf_rd_en) intf.buf_rd_data <= word(intf.buf_rd_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        logic [7:0] rdy_pat;
        int         exp_beats;
        logic [3:0] exp_lmask;
        int         exp_done;
        int         exp_stall;
    } vec_t;

    vec_t vecs[8];

    task automatic run_tile(input vec_t v);
        int c, nb, nr, nv, dc;
        logic [63:0] pa;
        logic pstall;
        logic [3:0] em;
        intf.cmd_base  = v.base;
        intf.cmd_len   = v.len;
        intf.cmd_valid = 1'b1;
        intf.dn_ready  = 1'b1;
        #1;
        chk("cmd_ready_idle", 64'(intf.cmd_ready), 64'd1);
        step();
        intf.cmd_valid = 1'b0;
        chk("cmd_ready_busy", 64'(intf.cmd_ready), 64'd0);
        c = 1; nb = 0; nr = 0; nv = 0; dc = -1; pstall = 1'b0; pa = '0;
        while (dc < 0 && c < 300) begin
            intf.dn_ready = (c < 3 || c > 10) ? 1'b1 : v.rdy_pat[c-3];
            #1;
            if (pstall) chk("hold_a", intf.dn_a, pa);
            if (intf.buf_rd_en) begin
                chk("rd_addr", 64'(intf.buf_rd_addr), 64'(8'(v.base + 8'(nr))));
                nr++;
            end
            if (intf.dn_valid) nv++;
            if (intf.dn_valid && intf.dn_ready) begin
                em = (nb == v.exp_beats - 1) ? v.exp_lmask : 4'hf;
                if (nb == 0) chk("first_beat_cyc", 64'(c), 64'd3);
                chk("beat_mask", 64'(intf.dn_mask), 64'(em));
                chk("beat_last", 64'(intf.dn_last), 64'(nb == v.exp_beats - 1));
                chk("beat_data", intf.dn_a, mask_word(word(8'(v.base + 8'(nb))), em));
                nb++;
            end
            pstall = intf.dn_valid && !intf.dn_ready;
            pa = intf.dn_a;
            if (intf.done) dc = c;
            step();
            c++;
        end
        chk("done_cyc", 64'(dc), 64'(v.exp_done));
        chk("beat_count", 64'(nb), 64'(v.exp_beats));
        chk("read_count", 64'(nr), 64'(v.exp_beats));
        chk("valid_cycles", 64'(nv), 64'(v.exp_beats + v.exp_stall));
        chk("cmd_ready_back", 64'(intf.cmd_ready), 64'd1);
        chk("done_pulse_end", 64'(intf.done), 64'd0);
`ifdef STC_A_DN_CTRL_PERF_EN
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(v.exp_stall));
`endif
    endtask

    initial begin
        vecs[0] = '{8'h10, 9'd8,   8'hff, 2,  4'b1111, 5,  0};
        vecs[1] = '{8'h20, 9'd6,   8'hff, 2,  4'b0011, 5,  0};
        vecs[2] = '{8'h30, 9'd16,  8'hf9, 4,  4'b1111, 9,  2};
        vecs[3] = '{8'hff, 9'd8,   8'hff, 2,  4'b1111, 5,  0};
        vecs[4] = '{8'h40, 9'd0,   8'hff, 0,  4'b1111, 1,  0};
        vecs[5] = '{8'h50, 9'd1,   8'hff, 1,  4'b0001, 4,  0};
        vecs[6] = '{8'h60, 9'd7,   8'hff, 2,  4'b0111, 5,  0};
        vecs[7] = '{8'hfe, 9'd256, 8'hff, 64, 4'b1111, 67, 0};

        intf.cmd_valid = 1'b0;
        intf.cmd_base  = '0;
        intf.cmd_len   = '0;
        intf.dn_ready  = 1'b1;
        reset = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", 64'(intf.cmd_ready), 64'd1);
        chk("rst_rd_en", 64'(intf.buf_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(intf.buf_rd_addr), 64'd0);
        chk("rst_dn_valid", 64'(intf.dn_valid), 64'd0);
        chk("rst_dn_a", intf.dn_a, 64'd0);
        chk("rst_dn_mask", 64'(intf.dn_mask), 64'd0);
        chk("rst_dn_last", 64'(intf.dn_last), 64'd0);
        chk("rst_done", 64'(intf.done), 64'd0);
`ifdef STC_A_DN_CTRL_PERF_EN
        chk("rst_perf", 64'(perf_stall_cnt), 64'd0);
`endif
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_tile(vecs[i]);

        // Reset while reads are in flight; the stale read must be dropped.
        intf.cmd_base  = 8'h70;
        intf.cmd_len   = 9'd16;
        intf.cmd_valid = 1'b1;
        step();
        intf.cmd_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_cmd_ready", 64'(intf.cmd_ready), 64'd1);
        chk("mid_rst_dn_valid", 64'(intf.dn_valid), 64'd0);
        chk("mid_rst_rd_en", 64'(intf.buf_rd_en), 64'd0);
        step();
        chk("mid_rst_stale", 64'(intf.dn_valid), 64'd0);
        chk("mid_rst_done", 64'(intf.done), 64'd0);
        run_tile(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, errs);
        $finish;
    end
endmodule
